// File: rtl/filter_phase_ctrl.sv
// Two-phase non-overlapping clock sequencer for one switched-capacitor slice,
// with once-per-period comparator capture, valid/ready delivery and event count.
module filter_phase_ctrl #(
    parameter int CNT_W = 8,
    parameter int DT_W  = 4,
    parameter int EVT_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstb_i,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] ph_width,
    input  logic [DT_W-1:0]  dead_time,
    input  logic             compout,
    input  logic             pol,
    input  logic             polxevent,
    output logic             phi1,
    output logic             phi2,
    output logic             phi1b,
    output logic             phi2b,
    output logic             busy,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [2:0]       smp_data,
    output logic [EVT_W-1:0] evt_count,
    output logic             overrun
);

    localparam int C_W = (CNT_W > DT_W) ? CNT_W : DT_W;

    typedef enum logic [2:0] {IDLE, PH1, DT1, PH2, DT2} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic               w_load;
    logic [C_W-1:0]     r_cnt;
    logic [CNT_W-1:0]   r_w;
    logic [DT_W-1:0]    r_d;
    logic               r_en;
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic               r_phi1;
    logic               r_phi2;
    logic               r_phi1b;
    logic               r_phi2b;
    logic               r_busy;
    logic               r_valid;
    logic [2:0]         r_data;
    logic [EVT_W-1:0]   r_evt;
    logic               r_overrun;
    logic               w_phEnd;
    logic               w_dtEnd;
    logic               w_capture;

    assign w_phEnd   = (r_cnt == C_W'(r_w));
    assign w_dtEnd   = (r_cnt == (C_W'(r_d) - C_W'(1)));
    assign w_capture = (r_state == DT2) && w_dtEnd;

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: if (r_en) begin
                w_nextState = PH1;
                w_load      = 1'b1;
            end
            PH1: if (w_phEnd) w_nextState = DT1;
            DT1: if (w_dtEnd) w_nextState = PH2;
            PH2: if (w_phEnd) w_nextState = DT2;
            DT2: if (w_dtEnd) begin
                if (r_en) begin
                    w_nextState = PH1;
                    w_load      = 1'b1;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Phase outputs are decoded from the next state so they switch with the state register.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstb_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_w     <= '0;
            r_d     <= DT_W'(1);
            r_en    <= 1'b0;
            r_phi1  <= 1'b0;
            r_phi2  <= 1'b0;
            r_phi1b <= 1'b1;
            r_phi2b <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_en    <= en;
            r_state <= w_nextState;
            r_cnt   <= (w_nextState != r_state) ? '0 : r_cnt + C_W'(1);
            if (w_load) begin
                r_w <= ph_width;
                r_d <= (dead_time == '0) ? DT_W'(1) : dead_time;
            end
            r_phi1  <= (w_nextState == PH1);
            r_phi2  <= (w_nextState == PH2);
            r_phi1b <= (w_nextState != PH1);
            r_phi2b <= (w_nextState != PH2);
            r_busy  <= (w_nextState != IDLE);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstb_i) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_evt     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_sync1 <= {compout, pol, polxevent};
            r_sync2 <= r_sync1;
            if (w_capture) begin
                if (!r_valid || smp_ready) begin
                    r_data  <= r_sync2;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && smp_ready) begin
                r_valid <= 1'b0;
            end
            // Dropped captures still count events; clr wins over a same-cycle update.
            if (clr) begin
                r_evt     <= '0;
                r_overrun <= 1'b0;
            end else begin
                if (w_capture && r_sync2[0] && !(&r_evt)) begin
                    r_evt <= r_evt + EVT_W'(1);
                end
                if (w_capture && r_valid && !smp_ready) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign phi1      = r_phi1;
    assign phi2      = r_phi2;
    assign phi1b     = r_phi1b;
    assign phi2b     = r_phi2b;
    assign busy      = r_busy;
    assign smp_valid = r_valid;
    assign smp_data  = r_data;
    assign evt_count = r_evt;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_filter_phase_ctrl.sv
// Directed bench for filter_phase_ctrl: phase timing, capture handshake,
// overrun, event saturation (EVT_W=4 copy) and mid-operation reset.
module tb_filter_phase_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        clr;
    logic        smpReady;
    logic        compout;
    logic        pol;
    logic        polxevent;
    logic [7:0]  phWidth;
    logic [3:0]  deadTime;

    logic        phi1A, phi2A, phi1bA, phi2bA, busyA, validA, overrunA;
    logic [2:0]  dataA;
    logic [15:0] evtA;
    logic        phi1B, phi2B, phi1bB, phi2bB, busyB, validB, overrunB;
    logic [2:0]  dataB;
    logic [3:0]  evtB;

    int checks   = 0;
    int failures = 0;

    filter_phase_ctrl #(.CNT_W(8), .DT_W(4), .EVT_W(16)) u_dutA (
        .wb_clk_i(clk), .wb_rstb_i(rstn), .en(en), .clr(clr),
        .ph_width(phWidth), .dead_time(deadTime),
        .compout(compout), .pol(pol), .polxevent(polxevent),
        .phi1(phi1A), .phi2(phi2A), .phi1b(phi1bA), .phi2b(phi2bA),
        .busy(busyA), .smp_valid(validA), .smp_ready(smpReady),
        .smp_data(dataA), .evt_count(evtA), .overrun(overrunA)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    filter_phase_ctrl #(.CNT_W(8), .DT_W(4), .EVT_W(4)) u_dutB (
        .wb_clk_i(clk), .wb_rstb_i(rstn), .en(en), .clr(clr),
        .ph_width(phWidth), .dead_time(deadTime),
        .compout(compout), .pol(pol), .polxevent(polxevent),
        .phi1(phi1B), .phi2(phi2B), .phi1b(phi1bB), .phi2b(phi2bB),
        .busy(busyB), .smp_valid(validB), .smp_ready(smpReady),
        .smp_data(dataB), .evt_count(evtB), .overrun(overrunB)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic enV, input logic readyV, input logic [7:0] phV, input logic [3:0] dtV);
        en       = enV;
        smpReady = readyV;
        phWidth  = phV;
        deadTime = dtV;
    endtask

    initial begin
        int ph;
        int off;
        int expEvt;
        logic act, e1, e2, eV;

        rstn = 1'b0; clr = 1'b0;
        compout = 1'b1; pol = 1'b0; polxevent = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'd3, 4'd2);
        repeat (3) @(negedge clk);

        checkOutput("rst_phi1", phi1A, 1'b0);
        checkOutput("rst_phi2", phi2A, 1'b0);
        checkOutput("rst_phi1b", phi1bA, 1'b1);
        checkOutput("rst_phi2b", phi2bA, 1'b1);
        checkOutput("rst_busy", busyA, 1'b0);
        checkOutput("rst_valid", validA, 1'b0);
        checkOutput("rst_data", dataA, 3'b000);
        checkOutput("rst_evt", evtA, 16'd0);
        checkOutput("rst_overrun", overrunA, 1'b0);

        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // W=3, D=2: period 12, phi1 4 cycles, gap 2, phi2 4, gap 2; en drops mid-PH1 of period 4.
        applyStimulus(1'b1, 1'b1, 8'd3, 4'd2);
        for (int i = 1; i <= 52; i++) begin
            @(negedge clk);
            act = (i >= 2) && (i < 50);
            ph  = (i - 2) % 12;
            e1  = act && (ph < 4);
            e2  = act && (ph >= 6) && (ph < 10);
            eV  = (i >= 14) && (i <= 50) && (ph == 0);
            expEvt = (i >= 14) ? (((i - 2) / 12 > 4) ? 4 : (i - 2) / 12) : 0;
            checkOutput("t1_phi1", phi1A, e1);
            checkOutput("t1_phi2", phi2A, e2);
            checkOutput("t1_phi1b", phi1bA, !e1);
            checkOutput("t1_phi2b", phi2bA, !e2);
            checkOutput("t1_busy", busyA, act);
            checkOutput("t1_valid", validA, eV);
            checkOutput("t1_evt", evtA, expEvt);
            checkOutput("t1_phi1_n", phi1B, e1);
            checkOutput("t1_phi2_n", phi2B, e2);
            checkOutput("t1_phi1b_n", phi1bB, !e1);
            checkOutput("t1_phi2b_n", phi2bB, !e2);
            checkOutput("t1_busy_n", busyB, act);
            checkOutput("t1_valid_n", validB, eV);
            if (eV) begin
                checkOutput("t1_data", dataA, 3'b101);
                checkOutput("t1_data_n", dataB, 3'b101);
            end
            if (i == 39) en = 1'b0;
        end

        // W=0, D=0 (as 1): period 4; W=5 written during PH2 applies from the next PH1.
        applyStimulus(1'b1, 1'b1, 8'd0, 4'd0);
        for (int j = 1; j <= 21; j++) begin
            @(negedge clk);
            act = (j >= 2) && (j < 20);
            if (j < 6) begin
                off = j - 2;
                e1 = act && (off == 0);
                e2 = act && (off == 2);
            end else begin
                off = j - 6;
                e1 = act && (off < 6);
                e2 = act && (off >= 7) && (off <= 12);
            end
            checkOutput("t2_phi1", phi1A, e1);
            checkOutput("t2_phi2", phi2A, e2);
            checkOutput("t2_busy", busyA, act);
            checkOutput("t2_valid", validA, (j == 6) || (j == 20));
            checkOutput("t2_evt", evtA, (j >= 20) ? 6 : ((j >= 6) ? 5 : 4));
            if (j == 4) phWidth = 8'd5;
            if (j == 6) en = 1'b0;
        end

        // Consumer stalled: first sample held, later captures dropped but counted.
        applyStimulus(1'b1, 1'b0, 8'd0, 4'd1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 6) begin
                checkOutput("t3_valid1", validA, 1'b1);
                checkOutput("t3_data1", dataA, 3'b101);
                checkOutput("t3_evt1", evtA, 16'd7);
                checkOutput("t3_ovr1", overrunA, 1'b0);
                compout = 1'b0;
            end
            if (k == 10) begin
                checkOutput("t3_data2", dataA, 3'b101);
                checkOutput("t3_evt2", evtA, 16'd8);
                checkOutput("t3_ovr2", overrunA, 1'b1);
            end
            if (k == 14) begin
                checkOutput("t3_evt3", evtA, 16'd9);
                en = 1'b0;
            end
            if (k == 18) begin
                checkOutput("t3_evt4", evtA, 16'd10);
                checkOutput("t3_ovr4", overrunA, 1'b1);
                checkOutput("t3_busy4", busyA, 1'b0);
                checkOutput("t3_data4", dataA, 3'b101);
            end
            if (k == 19) clr = 1'b1;
            if (k == 20) begin
                clr = 1'b0;
                checkOutput("t3_clr_evt", evtA, 16'd0);
                checkOutput("t3_clr_ovr", overrunA, 1'b0);
                checkOutput("t3_clr_evt_n", evtB, 4'd0);
                checkOutput("t3_clr_ovr_n", overrunB, 1'b0);
                checkOutput("t3_held_valid", validA, 1'b1);
                checkOutput("t3_held_data_n", dataB, 3'b101);
            end
        end

        // Ready raised only on the capture cycle while a stale sample is pending.
        applyStimulus(1'b1, 1'b0, 8'd0, 4'd1);
        for (int m = 1; m <= 12; m++) begin
            @(negedge clk);
            if (m == 5) smpReady = 1'b1;
            if (m == 6) begin
                checkOutput("t4_valid", validA, 1'b1);
                checkOutput("t4_data", dataA, 3'b001);
                checkOutput("t4_ovr", overrunA, 1'b0);
                checkOutput("t4_evt", evtA, 16'd1);
                smpReady = 1'b0;
                en = 1'b0;
            end
            if (m == 10) begin
                checkOutput("t4_ovr2", overrunA, 1'b1);
                checkOutput("t4_evt2", evtA, 16'd2);
                checkOutput("t4_data2", dataA, 3'b001);
                checkOutput("t4_busy2", busyA, 1'b0);
            end
            if (m == 11) clr = 1'b1;
            if (m == 12) clr = 1'b0;
        end

        // 20 captures with polxevent=1: wide counter reaches 20, narrow one stops at 15.
        applyStimulus(1'b1, 1'b1, 8'd0, 4'd0);
        for (int n = 1; n <= 82; n++) begin
            @(negedge clk);
            if (n == 62) begin
                checkOutput("t5_evt15", evtA, 16'd15);
                checkOutput("t5_evt15_n", evtB, 4'd15);
            end
            if (n == 66) begin
                checkOutput("t5_evt16", evtA, 16'd16);
                checkOutput("t5_sat16_n", evtB, 4'd15);
            end
            if (n == 80) en = 1'b0;
            if (n == 81) smpReady = 1'b0;
            if (n == 82) begin
                checkOutput("t5_evt20", evtA, 16'd20);
                checkOutput("t5_sat20_n", evtB, 4'd15);
                checkOutput("t5_valid", validA, 1'b1);
                checkOutput("t5_busy", busyA, 1'b0);
            end
        end

        // Reset pulled in the middle of PH2.
        applyStimulus(1'b1, 1'b0, 8'd3, 4'd2);
        for (int r = 1; r <= 10; r++) begin
            @(negedge clk);
            if (r == 9) begin
                checkOutput("t6_phi2_pre", phi2A, 1'b1);
                checkOutput("t6_valid_pre", validA, 1'b1);
                rstn = 1'b0;
            end
            if (r == 10) begin
                checkOutput("t6_phi2", phi2A, 1'b0);
                checkOutput("t6_phi2b", phi2bA, 1'b1);
                checkOutput("t6_valid", validA, 1'b0);
                checkOutput("t6_evt", evtA, 16'd0);
                checkOutput("t6_evt_n", evtB, 4'd0);
                checkOutput("t6_busy", busyA, 1'b0);
                checkOutput("t6_data", dataA, 3'b000);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/filter_phase_ctrl.md
# filter_phase_ctrl

Sequencer for one switched-capacitor filter/comparator slice. It generates the non-overlapping two-phase clocks phi1/phi2 and their complements with programmable phase width and dead time. Once per period it captures the slice's comparator outputs (compout, pol, polxevent) and delivers them over a valid/ready handshake. It also keeps a saturating event count. One instance sits between the user-project control logic and each filter_p_m_fin-style analog slice.

## Interface
- CNT_W, 8: width of phase-width setting
- DT_W, 4: width of dead-time setting
- EVT_W, 16: width of event counter
- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rstb_i  in  1  reset, synchronous, active-low
- en  in  1  run enable
- clr  in  1  synchronous clear of evt_count and overrun
- ph_width  in  CNT_W  each phase high time = ph_width+1 cycles
- dead_time  in  DT_W  non-overlap gap in cycles; 0 treated as 1
- compout, pol, polxevent  in  1 each  asynchronous outputs from the analog slice
- phi1, phi2  out  1  non-overlapping phase clocks
- phi1b, phi2b  out  1  exact complements of phi1/phi2
- busy  out  1  FSM not in IDLE
- smp_valid  out  1  captured sample available
- smp_ready  in  1  consumer accepts sample
- smp_data  out  3  {compout, pol, polxevent} captured
- evt_count  out  EVT_W  number of captured samples with polxevent=1, saturating
- overrun  out  1  sticky; a capture was dropped

## Operation
- FSM states: IDLE, PH1, DT1, PH2, DT2.
- IDLE -> PH1 when en=1.
- PH1 -> DT1 after W+1 cycles.
- DT1 -> PH2 after D cycles.
- PH2 -> DT2 after W+1 cycles.
- DT2 -> PH1 after D cycles if en=1, else DT2 -> IDLE.
- W and D are latched from ph_width and max(dead_time,1) on every entry to PH1. Mid-period config changes have no effect until the next period.
- Period = 2(W+1)+2D cycles.
- phi1=1 only in PH1. phi2=1 only in PH2. phi1 and phi2 are never both high.
- All four phase outputs are registered, with no glitches.
- en falling mid-period never truncates a phase: the current period completes through DT2, then the FSM goes to IDLE.
- The three analog inputs pass through 2-flop synchronizers. The capture takes the synchronized value on the last cycle of DT2, i.e. raw inputs 2 cycles earlier.
- Capture delivery:
  - if smp_valid=0, or smp_ready=1 in the same cycle: load smp_data and set smp_valid=1.
  - else: drop the new sample, keep the old smp_data, set overrun=1.
- smp_valid clears on smp_valid&smp_ready with no simultaneous capture.
- evt_count increments on every capture with polxevent=1, including dropped captures. It holds at 2^EVT_W-1.
- clr zeroes evt_count and overrun; clr has priority over a same-cycle increment.
- Reset values: state=IDLE, phi1=phi2=0, phi1b=phi2b=1, busy=0, smp_valid=0, smp_data=0, evt_count=0, overrun=0, synchronizers=0.

## Timing
- en sampled high at edge k: PH1 entered and phi1=1 from edge k+1.
- busy=1 whenever state≠IDLE.
- smp_valid rises on the edge after the last DT2 cycle, coincident with phi1 rising for the next period or with the IDLE return.
- The evt_count update and the smp_valid rise happen on the same edge.
- smp_ready is combinationally used only for load/clear decisions. There is no combinational path to any output.
- Reset asserted mid-operation:
  - all outputs take reset values on the next edge.
  - phi1/phi2 drop without completing the phase (the only permitted truncation).
  - no partial sample is delivered.
- Exact event arithmetic: evt_count is unsigned EVT_W bits. A saturated counter stays saturated until clr or reset.

## Test plan
- Reset, then en=1, ph_width=3, dead_time=2:
  - phi1 high 4 cycles, gap 2, phi2 high 4, gap 2; period 12.
  - phi1&phi2 never both 1; phiNb always equals ~phiN.
- dead_time=0, ph_width=0 -> period 4 (1,1,1,1). A ph_width change to 5 mid-PH2 takes effect only at the next PH1.
- polxevent=1, compout=1, pol=0 held steady, smp_ready=1 -> one smp_valid pulse per period with smp_data=3'b101; evt_count counts 1,2,3,…
- smp_ready=0 for 3 periods:
  - first sample held.
  - overrun=1 after the second capture.
  - evt_count still increments every period.
  - clr -> evt_count=0, overrun=0.
- EVT_W=4 build, polxevent=1 for 20 periods -> evt_count stops at 15. smp_ready=1 asserted on the exact capture cycle -> new sample loaded, no overrun.
- en=0 mid-PH1 -> period completes, then IDLE with phi1=phi2=0 and busy=0. wb_rstb_i=0 mid-PH2 -> phi2=0, phi2b=1, smp_valid=0, evt_count=0 on the next edge.
